// File: rtl/agc_pkg.sv
// rtl/agc_pkg.sv - shared AGC pipeline types and counter helper
package agc_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RAMSTALL = 2'd1,
    FLUSH    = 2'd2,
    HALT     = 2'd3
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_WR1  = 2'd1,
    FWD_WR2  = 2'd2
  } fwd_sel_t;

  // Sequencing counters never hold 0 while live, so every load is clamped to 1..7.
  function automatic logic [2:0] clamp_cnt(input int v);
    logic [2:0] r;
    if (v < 1) r = 3'd1;
    else if (v > 7) r = 3'd7;
    else r = 3'(v);
    return r;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational register and erasable-RAM hazard detection
module hazard_detect (
  input  logic        d_valid,
  input  logic [3:0]  d_rs2_sel,
  input  logic        d_uses_reg,
  input  logic        d_uses_ram,
  input  logic [11:0] d_addr,
  input  logic        e_valid,
  input  logic        e_wr1_en,
  input  logic        e_wr2_en,
  input  logic [3:0]  e_wr1_sel,
  input  logic [3:0]  e_wr2_sel,
  input  logic        e_ram_we,
  input  logic [11:0] e_addr,
  output logic        reg_hz_wr1,
  output logic        reg_hz_wr2,
  output logic        ram_hz
);

  logic w_reg_live;

  assign w_reg_live = d_valid & d_uses_reg & e_valid;
  assign reg_hz_wr1 = w_reg_live & e_wr1_en & (e_wr1_sel == d_rs2_sel);
  assign reg_hz_wr2 = w_reg_live & e_wr2_en & (e_wr2_sel == d_rs2_sel);
  assign ram_hz     = d_valid & d_uses_ram & e_valid & e_ram_we & (d_addr == e_addr);

endmodule

// File: rtl/register.sv
// rtl/register.sv - generic D register with asynchronous active-low reset
module register #(
  parameter int             W   = 1,
  parameter logic [W-1:0]   RST = '0
) (
  input  logic         clock,
  input  logic         rst_l,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) o_q <= RST;
    else        o_q <= i_d;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - AGC pipeline stall/flush/halt sequencer
// HAZARD_FWD_EN: resolve register hazards by forwarding instead of a one-cycle stall.
module hazard_ctrl
  import agc_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int RAM_LAT      = 2
) (
  input  logic        clock,
  input  logic        rst_l,
  input  logic        d_valid,
  input  logic [3:0]  d_rs2_sel,
  input  logic        d_uses_reg,
  input  logic        d_uses_ram,
  input  logic [11:0] d_addr,
  input  logic        d_halt,
  input  logic        e_valid,
  input  logic        e_wr1_en,
  input  logic        e_wr2_en,
  input  logic [3:0]  e_wr1_sel,
  input  logic [3:0]  e_wr2_sel,
  input  logic        e_ram_we,
  input  logic [11:0] e_addr,
  input  logic        e_branch_taken,
  input  logic [11:0] e_target,
  input  logic        resume,
  output logic        stall_F,
  output logic        stall_D,
  output logic        bubble_E,
  output logic        flush,
  output logic        pc_sel,
  output logic [11:0] pc_target,
  output logic        halted,
  output logic [1:0]  fwd_sel
);

  localparam logic [2:0] FLUSH_LOAD = clamp_cnt(FLUSH_CYCLES - 1);
  localparam logic [2:0] RAM_LOAD   = clamp_cnt(RAM_LAT - 1);
  localparam hz_state_t  BR_STATE   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
  localparam hz_state_t  RAM_STATE  = (RAM_LAT > 1) ? RAMSTALL : RUN;

  logic       w_reg_hz_wr1, w_reg_hz_wr2, w_ram_hz;
  logic       w_branch, w_halt;
  logic [1:0] w_state_q;
  hz_state_t  w_state, w_state_nxt;
  logic [2:0] w_cnt, w_cnt_nxt;

  hazard_detect u_detect (
    .d_valid    (d_valid),
    .d_rs2_sel  (d_rs2_sel),
    .d_uses_reg (d_uses_reg),
    .d_uses_ram (d_uses_ram),
    .d_addr     (d_addr),
    .e_valid    (e_valid),
    .e_wr1_en   (e_wr1_en),
    .e_wr2_en   (e_wr2_en),
    .e_wr1_sel  (e_wr1_sel),
    .e_wr2_sel  (e_wr2_sel),
    .e_ram_we   (e_ram_we),
    .e_addr     (e_addr),
    .reg_hz_wr1 (w_reg_hz_wr1),
    .reg_hz_wr2 (w_reg_hz_wr2),
    .ram_hz     (w_ram_hz)
  );

  register #(.W(2), .RST(RUN)) u_state_reg (
    .clock (clock),
    .rst_l (rst_l),
    .i_d   (w_state_nxt),
    .o_q   (w_state_q)
  );

  register #(.W(3), .RST(3'd0)) u_cnt_reg (
    .clock (clock),
    .rst_l (rst_l),
    .i_d   (w_cnt_nxt),
    .o_q   (w_cnt)
  );

  assign w_state   = hz_state_t'(w_state_q);
  assign w_branch  = e_valid & e_branch_taken;
  assign w_halt    = d_valid & d_halt;
  assign pc_target = e_target;
  assign halted    = (w_state == HALT);

  always_comb begin
    stall_F     = 1'b0;
    stall_D     = 1'b0;
    bubble_E    = 1'b0;
    flush       = 1'b0;
    pc_sel      = 1'b0;
    fwd_sel     = FWD_NONE;
    w_state_nxt = w_state;
    w_cnt_nxt   = w_cnt;
    unique case (w_state)
      RUN, RAMSTALL: begin
        if (w_branch) begin
          // The flush also clears decode's EXTEND/INDEX latches, so no prefix survives.
          flush       = 1'b1;
          pc_sel      = 1'b1;
          w_state_nxt = BR_STATE;
          w_cnt_nxt   = FLUSH_LOAD;
        end else if (w_state == RAMSTALL) begin
          stall_F  = 1'b1;
          stall_D  = 1'b1;
          bubble_E = 1'b1;
          if (w_cnt <= 3'd1) w_state_nxt = RUN;
          else               w_cnt_nxt   = w_cnt - 3'd1;
        end else if (w_halt) begin
          stall_F     = 1'b1;
          stall_D     = 1'b1;
          bubble_E    = 1'b1;
          w_state_nxt = HALT;
        end else if (w_ram_hz) begin
          stall_F     = 1'b1;
          stall_D     = 1'b1;
          bubble_E    = 1'b1;
          w_state_nxt = RAM_STATE;
          w_cnt_nxt   = RAM_LOAD;
        end else if (w_reg_hz_wr1 | w_reg_hz_wr2) begin
`ifdef HAZARD_FWD_EN
          fwd_sel = w_reg_hz_wr1 ? FWD_WR1 : FWD_WR2;
`else
          stall_F  = 1'b1;
          stall_D  = 1'b1;
          bubble_E = 1'b1;
`endif
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (w_branch) begin
          pc_sel    = 1'b1;
          w_cnt_nxt = FLUSH_LOAD;
        end else if (w_cnt <= 3'd1) begin
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = w_cnt - 3'd1;
        end
      end
      HALT: begin
        if (resume) begin
          // Release cycle: stalls drop and the flush discards the halt instruction.
          flush       = 1'b1;
          w_state_nxt = RUN;
        end else begin
          stall_F  = 1'b1;
          stall_D  = 1'b1;
          bubble_E = 1'b1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clock = 1'b0;
  logic        rst_l;
  logic        d_valid, d_uses_reg, d_uses_ram, d_halt;
  logic [3:0]  d_rs2_sel;
  logic [11:0] d_addr;
  logic        e_valid, e_wr1_en, e_wr2_en, e_ram_we, e_branch_taken, resume;
  logic [3:0]  e_wr1_sel, e_wr2_sel;
  logic [11:0] e_addr, e_target;
  logic        stall_F, stall_D, bubble_E, flush, pc_sel, halted;
  logic [11:0] pc_target;
  logic [1:0]  fwd_sel;

  always #5 clock = ~clock;

  hazard_ctrl #(.FLUSH_CYCLES(2), .RAM_LAT(2)) dut (
    .clock(clock), .rst_l(rst_l),
    .d_valid(d_valid), .d_rs2_sel(d_rs2_sel), .d_uses_reg(d_uses_reg),
    .d_uses_ram(d_uses_ram), .d_addr(d_addr), .d_halt(d_halt),
    .e_valid(e_valid), .e_wr1_en(e_wr1_en), .e_wr2_en(e_wr2_en),
    .e_wr1_sel(e_wr1_sel), .e_wr2_sel(e_wr2_sel), .e_ram_we(e_ram_we),
    .e_addr(e_addr), .e_branch_taken(e_branch_taken), .e_target(e_target),
    .resume(resume),
    .stall_F(stall_F), .stall_D(stall_D), .bubble_E(bubble_E), .flush(flush),
    .pc_sel(pc_sel), .pc_target(pc_target), .halted(halted), .fwd_sel(fwd_sel)
  );

  // Expected output packing: {stall_F, stall_D, bubble_E, flush, pc_sel, halted, fwd_sel[1:0]}
  localparam logic [7:0] E_NONE   = 8'b000_00_0_00;
  localparam logic [7:0] E_STALL  = 8'b111_00_0_00;
  localparam logic [7:0] E_BR     = 8'b000_11_0_00;
  localparam logic [7:0] E_FLUSH  = 8'b000_10_0_00;
  localparam logic [7:0] E_HALT   = 8'b111_00_1_00;
  localparam logic [7:0] E_RESUME = 8'b000_10_1_00;
`ifdef HAZARD_FWD_EN
  localparam logic [7:0] E_R1 = 8'b000_00_0_01;
  localparam logic [7:0] E_R2 = 8'b000_00_0_10;
`else
  localparam logic [7:0] E_R1 = E_STALL;
  localparam logic [7:0] E_R2 = E_STALL;
`endif

  typedef struct {
    logic        d_valid, d_uses_reg, d_uses_ram, d_halt;
    logic [3:0]  d_rs2_sel;
    logic [11:0] d_addr;
    logic        e_valid, e_wr1_en, e_wr2_en, e_ram_we, e_branch_taken, resume;
    logic [3:0]  e_wr1_sel, e_wr2_sel;
    logic [11:0] e_addr, e_target;
    logic [7:0]  exp_o;
  } vec_t;

  typedef struct {
    logic [7:0]  o;
    logic [11:0] tgt;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t v_idle(input logic [7:0] e);
    vec_t v;
    v = '{default: '0};
    v.e_target = 12'o1234;
    v.exp_o    = e;
    return v;
  endfunction

  function automatic vec_t v_br(input logic [11:0] tgt, input logic [7:0] e);
    vec_t v;
    v = v_idle(e);
    v.e_valid = 1'b1; v.e_branch_taken = 1'b1; v.e_target = tgt;
    return v;
  endfunction

  function automatic vec_t v_ram(input logic [11:0] da, input logic [11:0] ea, input logic [7:0] e);
    vec_t v;
    v = v_idle(e);
    v.d_valid = 1'b1; v.d_uses_ram = 1'b1; v.d_addr = da;
    v.e_valid = 1'b1; v.e_ram_we = 1'b1; v.e_addr = ea;
    return v;
  endfunction

  function automatic vec_t v_reg(input logic [3:0] rs2, input logic uses, input logic en1,
                                 input logic [3:0] s1, input logic en2, input logic [3:0] s2,
                                 input logic [7:0] e);
    vec_t v;
    v = v_idle(e);
    v.d_valid = 1'b1; v.d_uses_reg = uses; v.d_rs2_sel = rs2; v.e_valid = 1'b1;
    v.e_wr1_en = en1; v.e_wr1_sel = s1; v.e_wr2_en = en2; v.e_wr2_sel = s2;
    return v;
  endfunction

  function automatic vec_t v_halt(input logic [7:0] e);
    vec_t v;
    v = v_idle(e);
    v.d_valid = 1'b1; v.d_halt = 1'b1;
    return v;
  endfunction

  function automatic vec_t v_resume(input logic [7:0] e);
    vec_t v;
    v = v_idle(e);
    v.resume = 1'b1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    exp_t x;
    d_valid = v.d_valid; d_uses_reg = v.d_uses_reg; d_uses_ram = v.d_uses_ram; d_halt = v.d_halt;
    d_rs2_sel = v.d_rs2_sel; d_addr = v.d_addr;
    e_valid = v.e_valid; e_wr1_en = v.e_wr1_en; e_wr2_en = v.e_wr2_en; e_ram_we = v.e_ram_we;
    e_branch_taken = v.e_branch_taken; resume = v.resume;
    e_wr1_sel = v.e_wr1_sel; e_wr2_sel = v.e_wr2_sel; e_addr = v.e_addr; e_target = v.e_target;
    x.o   = v.exp_o;
    x.tgt = v.e_target;
    sb.push_back(x);
  endtask

  task automatic check_out(input string nm, input int id);
    exp_t       x;
    logic [7:0] act;
    act = {stall_F, stall_D, bubble_E, flush, pc_sel, halted, fwd_sel};
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s[%0d] scoreboard empty, no expectation queued", nm, id);
    end else begin
      x = sb.pop_front();
      if (act !== x.o) begin
        n_fail++;
        $display("FAIL %s[%0d] outputs {sF,sD,bE,fl,pc,ha,fwd} got %b expected %b", nm, id, act, x.o);
      end
      n_checks++;
      if (pc_target !== x.tgt) begin
        n_fail++;
        $display("FAIL %s[%0d] pc_target got %o expected %o", nm, id, pc_target, x.tgt);
      end
    end
  endtask

  task automatic step(input vec_t v, input string nm, input int id);
    @(posedge clock);
    #1;
    drive(v);
    #4;
    check_out(nm, id);
  endtask

  initial begin
    tbl.push_back(v_idle(E_NONE));
    tbl.push_back(v_br(12'o4000, E_BR));
    tbl.push_back(v_idle(E_FLUSH));
    tbl.push_back(v_idle(E_NONE));
    tbl.push_back(v_ram(12'o0100, 12'o0100, E_STALL));
    tbl.push_back(v_ram(12'o0100, 12'o0100, E_STALL));
    tbl.push_back(v_idle(E_NONE));
    tbl.push_back(v_ram(12'o0101, 12'o0100, E_NONE));
    tbl.push_back(v_reg(4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd7, E_R1));
    tbl.push_back(v_reg(4'd5, 1'b1, 1'b1, 4'd2, 1'b1, 4'd5, E_R2));
    tbl.push_back(v_reg(4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 4'd3, E_R1));
    tbl.push_back(v_reg(4'd6, 1'b1, 1'b0, 4'd6, 1'b0, 4'd6, E_NONE));
    tbl.push_back(v_reg(4'd4, 1'b0, 1'b1, 4'd4, 1'b0, 4'd0, E_NONE));
    begin
      vec_t bh;
      bh = v_br(12'o2345, E_BR);
      bh.d_valid = 1'b1; bh.d_halt = 1'b1;
      tbl.push_back(bh);
    end
    tbl.push_back(v_idle(E_FLUSH));
    tbl.push_back(v_idle(E_NONE));
    tbl.push_back(v_halt(E_STALL));
    for (int i = 0; i < 10; i++) tbl.push_back(v_idle(E_HALT));
    tbl.push_back(v_resume(E_RESUME));
    tbl.push_back(v_idle(E_NONE));
    tbl.push_back(v_resume(E_NONE));
    tbl.push_back(v_br(12'o0777, E_BR));
    tbl.push_back(v_br(12'o1111, E_BR));
    tbl.push_back(v_idle(E_FLUSH));
    tbl.push_back(v_idle(E_NONE));
    tbl.push_back(v_ram(12'o0200, 12'o0200, E_STALL));
    tbl.push_back(v_br(12'o3210, E_BR));
    tbl.push_back(v_idle(E_FLUSH));
    tbl.push_back(v_idle(E_NONE));
    begin
      vec_t nb;
      nb = v_br(12'o0042, E_NONE);
      nb.e_valid = 1'b0;
      tbl.push_back(nb);
    end

    rst_l = 1'b0;
    drive(v_idle(E_NONE));
    #3;
    check_out("reset", 0);
    #19;
    rst_l = 1'b1;

    foreach (tbl[i]) step(tbl[i], "vec", i);

    // Reset in the first FLUSH cycle must drop the sequencer back to RUN at once.
    step(v_br(12'o4000, E_BR), "rst_flush_br", 0);
    @(posedge clock);
    #1;
    drive(v_idle(E_NONE));
    rst_l = 1'b0;
    #1;
    check_out("rst_flush_now", 0);
    @(negedge clock);
    rst_l = 1'b1;
    step(v_idle(E_NONE), "rst_flush_after", 0);

    // Same for a reset taken while halted.
    step(v_halt(E_STALL), "rst_halt_enter", 0);
    step(v_idle(E_HALT), "rst_halt_hold", 0);
    @(posedge clock);
    #1;
    drive(v_idle(E_NONE));
    rst_l = 1'b0;
    #1;
    check_out("rst_halt_now", 0);
    @(negedge clock);
    rst_l = 1'b1;
    step(v_idle(E_NONE), "rst_halt_after", 0);

    // And while in RAMSTALL.
    step(v_ram(12'o0300, 12'o0300, E_STALL), "rst_ram_enter", 0);
    @(posedge clock);
    #1;
    drive(v_idle(E_NONE));
    rst_l = 1'b0;
    #1;
    check_out("rst_ram_now", 0);
    @(negedge clock);
    rst_l = 1'b1;
    step(v_idle(E_NONE), "rst_ram_after", 0);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left %0d expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the AGC core. Sits beside `decode` and drives its `flush` input, and holds the fetch/decode stages on data hazards. Decides when execute receives a bubble, and redirects the PC on taken branches. Owns the HALT state entered by halt-class instructions. Also prevents an EXTEND/INDEX prefix from surviving a taken branch, because `flush` clears both prefix latches in `decode`.

## Interface
Parameters:
- FLUSH_CYCLES, 2, cycles `flush` stays asserted after a taken branch (range 1..7)
- RAM_LAT, 2, stall cycles for an erasable-RAM read-after-write hazard (range 1..7)

Ports:
- clock  in  1  single clock, rising edge
- rst_l  in  1  asynchronous, active-low reset
- d_valid  in  1  decode holds a real instruction
- d_rs2_sel  in  4  register read by the decode instruction (`ctrl_D.rs2_sel`)
- d_uses_reg  in  1  decode reads a register operand
- d_uses_ram  in  1  decode reads erasable RAM
- d_addr  in  12  decode operand address (`ctrl_D.K`)
- d_halt  in  1  decode instruction is halt-class (`ctrl_D.halt`)
- e_valid  in  1  execute holds a real instruction
- e_wr1_en, e_wr2_en  in  1 each  execute register write enables
- e_wr1_sel, e_wr2_sel  in  4 each  execute destination registers
- e_ram_we  in  1  execute writes erasable RAM
- e_addr  in  12  execute RAM address
- e_branch_taken  in  1  execute resolved a taken branch
- e_target  in  12  branch target
- resume  in  1  single-cycle pulse that releases HALT
- stall_F, stall_D  out  1 each  hold the PC and the decode input register
- bubble_E  out  1  insert a NOP into execute
- flush  out  1  to `decode.flush`; kills fetch/decode contents
- pc_sel  out  1  1 selects `pc_target`
- pc_target  out  12  equals `e_target`
- halted  out  1  the core is in HALT
- fwd_sel  out  2  operand-2 forward select: 0 none, 1 from wr1, 2 from wr2

## Operation
States are RUN, RAMSTALL, FLUSH and HALT.

Priority in RUN, evaluated combinationally each cycle, highest first:
- **Branch.** Condition: `e_valid & e_branch_taken`.
  - Same cycle: `flush`=1 and `pc_sel`=1.
  - If FLUSH_CYCLES>1: go to FLUSH with `cnt`=FLUSH_CYCLES-1. Otherwise stay in RUN.
- **Halt.** Condition: `d_valid & d_halt`.
  - Same cycle: `stall_F`=1, `stall_D`=1, `bubble_E`=1.
  - Next state: HALT.
- **RAM hazard.** Condition: `d_valid & d_uses_ram & e_valid & e_ram_we & (d_addr==e_addr)`.
  - Same cycle: `stall_F`=1, `stall_D`=1, `bubble_E`=1.
  - If RAM_LAT>1: go to RAMSTALL with `cnt`=RAM_LAT-1.
- **Register hazard.** Condition: `d_valid & d_uses_reg & e_valid` and (`e_wr1_en & e_wr1_sel==d_rs2_sel` or `e_wr2_en & e_wr2_sel==d_rs2_sel`).
  - Handled by forwarding or by a stall, as set out under Configuration.

FLUSH:
- `flush`=1.
- Decrement `cnt`; go to RUN after the cycle in which `cnt`=1.
- A new taken branch in FLUSH reloads `cnt`=FLUSH_CYCLES-1 and asserts `pc_sel`.

RAMSTALL:
- `stall_F`, `stall_D` and `bubble_E` all =1.
- Decrement `cnt`; go to RUN after the cycle in which `cnt`=1.
- A taken branch here still wins: go to FLUSH as from RUN.

HALT:
- `halted`=1, `stall_F`=1, `stall_D`=1, `bubble_E`=1.
- On `resume`: one cycle with `flush`=1 and all stalls 0, which discards the halt instruction. Then go to RUN.
- `resume` has no effect outside HALT.

`cnt` is 3 bits. Values written to it are clamped to at least 1.

## Timing
- Reset: state RUN, `cnt`=0. Every output is 0 while `rst_l`=0 and in the first cycle after release, unless an input event asserts it.
- All stall, flush and fwd outputs are combinational from the current state and inputs, with zero-cycle latency. State and `cnt` are registered.
- A taken branch in execute gives exactly FLUSH_CYCLES cycles of `flush`, counting the detect cycle.
- A RAM hazard gives exactly RAM_LAT stall cycles.
- `pc_sel` is high for exactly one cycle per taken branch.
- Branch and halt in the same cycle: the branch wins, and the halt instruction is flushed.
- Reset asserted mid-FLUSH, mid-RAMSTALL or mid-HALT: immediately RUN, outputs 0.

## Configuration
HAZARD_FWD_EN controls register-hazard handling.

Defined:
- Register hazards never stall.
- `fwd_sel`=1 on a wr1 match, 2 on a wr2-only match. When both match, wr1 wins.

Undefined:
- `fwd_sel` is tied to 0.
- A register hazard asserts `stall_F`, `stall_D` and `bubble_E` for one cycle, with no state change.

RAM hazards stall in both builds.

## Structure
- Shared package `agc_pkg`: `hz_state_t` enum {RUN, RAMSTALL, FLUSH, HALT} and `fwd_sel_t` enum {FWD_NONE, FWD_WR1, FWD_WR2}.
- State and `cnt` registers use the existing `register` module.
- One combinational sub-module, `hazard_detect`: produces `reg_hz_wr1`, `reg_hz_wr2` and `ram_hz` from the d_*/e_* signals.

## Test plan
Each scenario runs with FLUSH_CYCLES=2 and RAM_LAT=2.

1. Taken branch: `e_branch_taken`=1 with `e_target`='o4000.
   - `pc_sel`=1 and `pc_target`='o4000 for 1 cycle.
   - `flush`=1 for 2 cycles; decode's extracode state is cleared.
2. RAM hazard: `e_ram_we`=1 and `e_addr`=`d_addr`='o0100 with `d_uses_ram`=1.
   - Stalls and bubble for 2 cycles.
   - No stall at `d_addr`='o0101.
3. Register hazard: `e_wr1_sel`=`d_rs2_sel`=0 (A).
   - With the macro: `fwd_sel`=1, no stall.
   - Without the macro: 1 stall cycle.
4. Halt: `d_halt`=1.
   - `halted`=1 from the next cycle, held for 10 cycles.
   - On `resume`: 1 `flush` cycle, then RUN and `halted`=0.
5. Branch and halt asserted in the same cycle → FLUSH, `halted` stays 0.
6. `rst_l` pulled low in the first FLUSH cycle → all outputs 0 immediately, state RUN after release.
